// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the 5-stage ARM pipeline control block.
package arm_pipe_pkg;

  // Default register-address width (16 architectural registers).
  localparam int DEF_REG_W = 4;

  // Width of the memory-wait down-counter; covers MEM_LAT up to 16.
  localparam int MW_CNT_W = 4;

  // EXE operand source select.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Memory wait FSM states.
  typedef enum logic {
    MW_IDLE = 1'b0,
    MW_BUSY = 1'b1
  } mw_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait: freezes the whole pipe for MEM_LAT-1 cycles
// of every access seen from IDLE.
module mem_wait_fsm
  import arm_pipe_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access_i,
  output logic freeze_all_o
);

  // MEM_LAT=1 accesses complete in a single cycle and never enter BUSY.
  localparam bit                  LONG = (MEM_LAT > 1);
  localparam logic [MW_CNT_W-1:0] LOAD = LONG ? MW_CNT_W'(MEM_LAT - 2) : '0;

  mw_state_e           state_q, state_d;
  logic [MW_CNT_W-1:0] cnt_q, cnt_d;
  logic                frz;

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MW_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and freeze; mem_access in BUSY belongs to the same access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frz     = 1'b0;
    case (state_q)
      MW_IDLE: begin
        if (mem_access_i && LONG) begin
          frz     = 1'b1;
          cnt_d   = LOAD;
          state_d = MW_BUSY;
        end
      end
      MW_BUSY: begin
        frz = (cnt_q != '0);
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = MW_IDLE;
      end
      default: state_d = MW_IDLE;
    endcase
  end

  // Gate with reset so a mid-BUSY reset drops the freeze immediately.
  assign freeze_all_o = frz & rst;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core: hazard stall, EXE forwarding,
// memory-wait freeze, branch flush and stall/flush performance counters.
module pipeline_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_W   = DEF_REG_W,
  parameter bit FWD_EN  = 1'b1,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_src1,
  input  logic [REG_W-1:0] exe_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             freeze_all,
  output logic             freeze_front,
  output logic             id_bubble,
  output logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             hazard;
  fwd_sel_e         sel_a, sel_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Does a producer (dest, en) write a register the ID instruction reads?
  function automatic logic id_match(input logic [REG_W-1:0] d, input logic en,
                                    input logic v, input logic [REG_W-1:0] s1,
                                    input logic [REG_W-1:0] s2, input logic two);
    return en && v && (d == s1 || (two && d == s2));
  endfunction

  // Per-operand forward source; MEM result is younger so it wins over WB.
  function automatic fwd_sel_e pick(input logic [REG_W-1:0] src);
    if (!FWD_EN)                       return FWD_REG;
    if (mem_wb_en && mem_dest == src)  return FWD_MEM;
    if (wb_wb_en  && wb_dest  == src)  return FWD_WB;
    return FWD_REG;
  endfunction

  mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
    .clk          (clk),
    .rst          (rst),
    .mem_access_i (mem_access),
    .freeze_all_o (freeze_all)
  );

  // Hazard: with forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN)
      hazard = id_match(exe_dest, exe_wb_en && exe_mem_r_en,
                        id_valid, id_src1, id_src2, id_two_src);
    else
      hazard = id_match(exe_dest, exe_wb_en, id_valid, id_src1, id_src2, id_two_src) ||
               id_match(mem_dest, mem_wb_en, id_valid, id_src1, id_src2, id_two_src);
  end

  // Forwarding selects for both EXE operands.
  always_comb begin
    sel_a = pick(exe_src1);
    sel_b = pick(exe_src2);
  end

  // Output priority: memory freeze > branch flush > hazard stall; all zero in reset.
  always_comb begin
    flush        = 1'b0;
    freeze_front = 1'b0;
    id_bubble    = 1'b0;
    fwd_sel_a    = 2'(FWD_REG);
    fwd_sel_b    = 2'(FWD_REG);
    if (rst) begin
      fwd_sel_a = 2'(sel_a);
      fwd_sel_b = 2'(sel_b);
      if (!freeze_all) begin
        flush        = branch_taken;
        freeze_front = hazard && !branch_taken;
        id_bubble    = hazard && !branch_taken;
      end
    end
  end

  // Saturating counter next state; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((freeze_all || freeze_front) && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != '1)                        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding/MEM_LAT=3 instance and a
// no-forwarding/MEM_LAT=1 instance driven by the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       mem_access, wb_wb_en, branch_taken, cnt_clr;
  logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;

  logic       fa1, ff1, bub1, fl1;
  logic [1:0] sa1, sb1;
  logic [2:0] sc1, fc1;
  logic       fa0, ff0, bub0, fl0;
  logic [1:0] sa0, sb0;
  logic [15:0] sc0, fc0;

  int total = 0;
  int bad   = 0;
  int    exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b1), .MEM_LAT(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .branch_taken(branch_taken),
    .cnt_clr(cnt_clr), .freeze_all(fa1), .freeze_front(ff1), .id_bubble(bub1),
    .flush(fl1), .fwd_sel_a(sa1), .fwd_sel_b(sb1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b0), .MEM_LAT(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .branch_taken(branch_taken),
    .cnt_clr(cnt_clr), .freeze_all(fa0), .freeze_front(ff0), .id_bubble(bub0),
    .flush(fl0), .fwd_sel_a(sa0), .fwd_sel_b(sb0), .stall_cnt(sc0), .flush_cnt(fc0));

  typedef struct {
    logic id_valid; logic [3:0] id_src1, id_src2; logic id_two_src;
    logic [3:0] exe_src1, exe_src2, exe_dest; logic exe_wb_en, exe_mem_r_en;
    logic [3:0] mem_dest; logic mem_wb_en; logic [3:0] wb_dest; logic wb_wb_en;
    logic br;
  } in_t;

  typedef struct {
    in_t i; int fa; int fb; int front; int flush; int front0;
  } vec_t;

  vec_t tbl[11];

  task automatic apply(input in_t x);
    id_valid = x.id_valid; id_src1 = x.id_src1; id_src2 = x.id_src2;
    id_two_src = x.id_two_src; exe_src1 = x.exe_src1; exe_src2 = x.exe_src2;
    exe_dest = x.exe_dest; exe_wb_en = x.exe_wb_en; exe_mem_r_en = x.exe_mem_r_en;
    mem_dest = x.mem_dest; mem_wb_en = x.mem_wb_en; wb_dest = x.wb_dest;
    wb_wb_en = x.wb_wb_en; branch_taken = x.br;
  endtask

  task automatic expect_v(input string n, input int v);
    nm_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input int act);
    string n;
    int    e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty actual=%0d", act);
    end else begin
      n = nm_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (act != e) begin
        bad++;
        $display("FAIL %s actual=%0d expected=%0d", n, act, e);
      end
    end
  endtask

  task automatic one(input string n, input int act, input int e);
    expect_v(n, e);
    check_v(act);
  endtask

  in_t z, t;

  initial begin
    z = '{default: '0};
    apply(z);
    mem_access = 1'b0; cnt_clr = 1'b0;

    // Table of combinational vectors, expectations worked out by hand.
    t = z; t.exe_src1 = 3; t.exe_src2 = 7; t.mem_dest = 3; t.mem_wb_en = 1;
    t.wb_dest = 3; t.wb_wb_en = 1; t.id_valid = 1; t.id_src1 = 9; t.id_src2 = 10;
    tbl[0] = '{t, 1, 0, 0, 0, 0};
    t.mem_wb_en = 0;
    tbl[1] = '{t, 2, 0, 0, 0, 0};
    t = z; t.exe_src1 = 6; t.exe_src2 = 4; t.mem_dest = 4; t.mem_wb_en = 1;
    t.wb_dest = 6; t.wb_wb_en = 1;
    tbl[2] = '{t, 2, 1, 0, 0, 0};
    t = z; t.exe_mem_r_en = 1; t.exe_wb_en = 1; t.exe_dest = 5; t.id_valid = 1;
    t.id_src1 = 1; t.id_src2 = 5; t.id_two_src = 1;
    tbl[3] = '{t, 0, 0, 1, 0, 1};
    t.id_two_src = 0;
    tbl[4] = '{t, 0, 0, 0, 0, 0};
    t = z; t.exe_wb_en = 1; t.exe_dest = 5; t.id_src1 = 5; t.id_valid = 1;
    tbl[5] = '{t, 0, 0, 0, 0, 1};
    t = z; t.mem_wb_en = 1; t.mem_dest = 2; t.id_src1 = 2; t.id_valid = 1; t.exe_src1 = 2;
    tbl[6] = '{t, 1, 0, 0, 0, 1};
    t = tbl[3].i; t.br = 1;
    tbl[7] = '{t, 0, 0, 0, 1, 0};
    t = tbl[3].i; t.id_valid = 0;
    tbl[8] = '{t, 0, 0, 0, 0, 0};
    t = tbl[3].i; t.exe_wb_en = 0;
    tbl[9] = '{t, 0, 0, 0, 0, 0};
    t = tbl[3].i; t.id_src1 = 5; t.id_src2 = 1;
    tbl[10] = '{t, 0, 0, 1, 0, 1};

    // Reset state: outputs forced low even with live inputs.
    t = tbl[0].i; t.br = 1; apply(t);
    #2;
    one("rst_flush", fl1, 0);
    one("rst_fwd_a", sa1, 0);
    one("rst_freeze_all", fa1, 0);
    one("rst_stall_cnt", sc1, 0);
    one("rst_flush_cnt", fc1, 0);
    apply(z);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Table sweep; counters held clear.
    cnt_clr = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      apply(tbl[k].i);
      expect_v($sformatf("v%0d_fwd_a", k), tbl[k].fa);
      expect_v($sformatf("v%0d_fwd_b", k), tbl[k].fb);
      expect_v($sformatf("v%0d_freeze_front", k), tbl[k].front);
      expect_v($sformatf("v%0d_id_bubble", k), tbl[k].front);
      expect_v($sformatf("v%0d_flush", k), tbl[k].flush);
      expect_v($sformatf("v%0d_freeze_all", k), 0);
      expect_v($sformatf("v%0d_nofwd_front", k), tbl[k].front0);
      expect_v($sformatf("v%0d_nofwd_bubble", k), tbl[k].front0);
      expect_v($sformatf("v%0d_nofwd_flush", k), tbl[k].i.br ? 1 : 0);
      expect_v($sformatf("v%0d_nofwd_sel_a", k), 0);
      expect_v($sformatf("v%0d_nofwd_sel_b", k), 0);
      #1;
      check_v(sa1); check_v(sb1); check_v(ff1); check_v(bub1); check_v(fl1);
      check_v(fa1); check_v(ff0); check_v(bub0); check_v(fl0); check_v(sa0); check_v(sb0);
    end

    // Branch over a load-use, then a plain load-use stall.
    @(negedge clk); apply(z);
    @(negedge clk); cnt_clr = 1'b0; apply(tbl[7].i);
    #1; one("brhaz_flush", fl1, 1); one("brhaz_front", ff1, 0);
    @(posedge clk); #1; one("brhaz_flush_cnt", fc1, 1);
    @(negedge clk); apply(tbl[3].i);
    @(posedge clk); #1; one("lu_stall_cnt", sc1, 1); one("lu_flush_cnt", fc1, 1);

    // Memory wait, MEM_LAT=3, overlapping branch.
    @(negedge clk); apply(z); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; mem_access = 1'b1; branch_taken = 1'b1;
    #1; one("mw0_freeze", fa1, 1); one("mw0_flush", fl1, 0); one("mw0_lat1_freeze", fa0, 0);
    @(negedge clk); mem_access = 1'b0;
    #1; one("mw1_freeze", fa1, 1); one("mw1_flush", fl1, 0);
    @(negedge clk); branch_taken = 1'b0;
    #1; one("mw2_freeze", fa1, 0);
    @(posedge clk); #1; one("mw_stall_cnt", sc1, 2); one("mw_flush_cnt", fc1, 0);

    // Back-to-back accesses: 1,1,0 repeating.
    @(negedge clk); cnt_clr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); cnt_clr = 1'b0; mem_access = 1'b1;
      #1; one($sformatf("b2b%0d_freeze", k), fa1, (k % 3 == 2) ? 0 : 1);
    end
    @(negedge clk); mem_access = 1'b0;
    #1; one("b2b_stall_cnt", sc1, 4); one("b2b_idle_freeze", fa1, 0);

    // Reset in the first BUSY cycle.
    @(negedge clk); mem_access = 1'b1;
    @(negedge clk); mem_access = 1'b0;
    #1; one("rb_busy_freeze", fa1, 1);
    branch_taken = 1'b1; rst = 1'b0;
    #1; one("rb_freeze", fa1, 0); one("rb_flush", fl1, 0);
    one("rb_stall_cnt", sc1, 0); one("rb_flush_cnt", fc1, 0);
    @(negedge clk); rst = 1'b1; branch_taken = 1'b0;
    #1; one("rb_idle_freeze", fa1, 0);
    @(negedge clk); mem_access = 1'b1;
    #1; one("rb_reentry_freeze", fa1, 1);
    @(negedge clk); mem_access = 1'b0;
    @(negedge clk); #1; one("rb_reentry_end", fa1, 0);

    // Saturation, then clear beating a simultaneous increment.
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; branch_taken = 1'b1;
    repeat (9) @(posedge clk);
    #1; one("sat_flush_cnt", fc1, 7);
    @(negedge clk); cnt_clr = 1'b1;
    @(posedge clk); #1; one("clr_flush_cnt", fc1, 0);
    @(negedge clk); cnt_clr = 1'b0;
    @(posedge clk); #1; one("post_clr_flush_cnt", fc1, 1);
    @(negedge clk); branch_taken = 1'b0;

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
